// File: rtl/alu_op_issue_pkg.sv
// Shared ALU operation encodings and ALUOp class values.
// Imported by the issue stage, its decoder and the ALU.
package alu_op_issue_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND     = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR      = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD     = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB     = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR     = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRL     = 4'b0101;
  localparam logic [OP_W-1:0] OP_LUI     = 4'b0111;
  localparam logic [OP_W-1:0] OP_EQ      = 4'b1000;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 4'b1001;
  localparam logic [OP_W-1:0] OP_SLT     = 4'b1100;
  localparam logic [OP_W-1:0] OP_SLL     = 4'b1110;
  localparam logic [OP_W-1:0] OP_SRA     = 4'b1111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_LUI    = 2'b11;

  // Funct7 value selecting SUB / SRA.
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'd255) begin
      return 8'd255;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/alu_op_issue_decode.sv
// Combinational decode of ALUOp/Funct3/Funct7/ALUSrc into an ALU Operation.
module alu_op_decode
  import alu_op_issue_pkg::*;
(
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      Funct3,
  input  logic [6:0]      Funct7,
  input  logic            ALUSrc,
  output logic [OP_W-1:0] Operation,
  output logic            illegal
);

  logic [OP_W-1:0] op_s;
  logic            alt_s;

  assign alt_s = (Funct7 == FUNCT7_ALT);

  // Class and function-field decode; anything unmapped is ILLEGAL.
  always_comb begin
    op_s = OP_ILLEGAL;
    case (ALUOp)
      ALUOP_MEM: op_s = OP_ADD;
      ALUOP_BRANCH: begin
        if (Funct3 == 3'b000 || Funct3 == 3'b001) begin
          op_s = OP_EQ;
        end else begin
          op_s = OP_ILLEGAL;
        end
      end
      ALUOP_ARITH: begin
        case (Funct3)
          3'b000: begin
            // Immediate forms never subtract, whatever Funct7 holds.
            if (!ALUSrc && alt_s) begin
              op_s = OP_SUB;
            end else begin
              op_s = OP_ADD;
            end
          end
          3'b001: op_s = OP_SLL;
          3'b010: op_s = OP_SLT;
          3'b100: op_s = OP_XOR;
          3'b101: begin
            if (alt_s) begin
              op_s = OP_SRA;
            end else begin
              op_s = OP_SRL;
            end
          end
          3'b110: op_s = OP_OR;
          3'b111: op_s = OP_AND;
          default: op_s = OP_ILLEGAL;
        endcase
      end
      ALUOP_LUI: op_s = OP_LUI;
      default: op_s = OP_ILLEGAL;
    endcase
  end

  assign Operation = op_s;
  assign illegal   = (op_s == OP_ILLEGAL);

endmodule

// File: rtl/alu_op_issue.sv
// Single-register issue stage: decodes the ALU operation and holds
// SrcA/SrcB/Operation behind a valid/ready handshake.
module alu_op_issue
  import alu_op_issue_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic                     ALUSrc,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    Imm,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     illegal,
  output logic [7:0]               illegal_count
);

  logic [OP_W-1:0]          op_s;
  logic                     illegal_s;
  logic                     accept_s;
  logic                     out_valid_r;
  logic [DATA_WIDTH-1:0]    srca_r;
  logic [DATA_WIDTH-1:0]    srcb_r;
  logic [OPCODE_LENGTH-1:0] operation_r;
  logic                     illegal_r;
  logic [7:0]               illegal_count_r;

  alu_op_decode u_decode (
    .ALUOp     (ALUOp),
    .Funct3    (Funct3),
    .Funct7    (Funct7),
    .ALUSrc    (ALUSrc),
    .Operation (op_s),
    .illegal   (illegal_s)
  );

  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready && !flush;

  // Pipeline register: reset beats flush, flush beats accept/drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r     <= 1'b0;
      srca_r          <= '0;
      srcb_r          <= '0;
      operation_r     <= '0;
      illegal_r       <= 1'b0;
      illegal_count_r <= 8'd0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      srca_r      <= rs1_data;
      srcb_r      <= ALUSrc ? Imm : rs2_data;
      operation_r <= OPCODE_LENGTH'(op_s);
      illegal_r   <= illegal_s;
      if (illegal_s) begin
        illegal_count_r <= sat_inc8(illegal_count_r);
      end else begin
        illegal_count_r <= illegal_count_r;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid     = out_valid_r;
  assign SrcA          = srca_r;
  assign SrcB          = srcb_r;
  assign Operation     = operation_r;
  assign illegal       = illegal_r;
  assign illegal_count = illegal_count_r;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue with hand-computed expectations.
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, ALUSrc, flush, out_valid, out_ready, illegal;
  logic [1:0]  ALUOp;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] rs1_data, rs2_data, Imm, SrcA, SrcB;
  logic [3:0]  Operation;
  logic [7:0]  illegal_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  typedef struct packed {
    logic [1:0] aluop;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       src;
    logic [3:0] op;
  } vec_t;

  vec_t vecs [16] = '{
    '{2'b10, 3'b000, 7'h20, 1'b0, 4'b0011},
    '{2'b10, 3'b000, 7'h20, 1'b1, 4'b0010},
    '{2'b10, 3'b000, 7'h00, 1'b0, 4'b0010},
    '{2'b10, 3'b101, 7'h20, 1'b1, 4'b1111},
    '{2'b10, 3'b101, 7'h00, 1'b1, 4'b0101},
    '{2'b10, 3'b001, 7'h00, 1'b0, 4'b1110},
    '{2'b10, 3'b010, 7'h00, 1'b0, 4'b1100},
    '{2'b10, 3'b100, 7'h00, 1'b0, 4'b0100},
    '{2'b10, 3'b110, 7'h00, 1'b0, 4'b0001},
    '{2'b10, 3'b111, 7'h00, 1'b0, 4'b0000},
    '{2'b10, 3'b011, 7'h00, 1'b0, 4'b1001},
    '{2'b00, 3'b011, 7'h20, 1'b0, 4'b0010},
    '{2'b01, 3'b000, 7'h00, 1'b0, 4'b1000},
    '{2'b01, 3'b001, 7'h00, 1'b0, 4'b1000},
    '{2'b01, 3'b100, 7'h00, 1'b0, 4'b1001},
    '{2'b11, 3'b101, 7'h20, 1'b0, 4'b0111}
  };

  alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7), .ALUSrc(ALUSrc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .Imm(Imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                       input logic src, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im);
    in_valid = 1'b1; ALUOp = a; Funct3 = f3; Funct7 = f7; ALUSrc = src;
    rs1_data = r1; rs2_data = r2; Imm = im;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_srca"}, SrcA, 32'd0);
    check_eq({tag, "_srcb"}, SrcB, 32'd0);
    check_eq({tag, "_op"}, {28'd0, Operation}, 32'd0);
    check_eq({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    check_eq({tag, "_count"}, {24'd0, illegal_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    ALUOp = 2'b00; Funct3 = 3'd0; Funct7 = 7'd0; ALUSrc = 1'b0;
    rs1_data = 32'd0; rs2_data = 32'd0; Imm = 32'd0;
    step(); step();
    reset = 1'b0;
    check_reset_state("rst");
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // SUB: register form with alternate Funct7.
    drive(2'b10, 3'b000, 7'h20, 1'b0, 32'd10, 32'd3, 32'd99);
    step();
    check_eq("sub_op", {28'd0, Operation}, 32'h3);
    check_eq("sub_srca", SrcA, 32'd10);
    check_eq("sub_srcb", SrcB, 32'd3);
    check_eq("sub_valid", {31'd0, out_valid}, 32'd1);

    // Decode table, back-to-back with out_ready=1.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].src,
            32'd100 + 32'(i), 32'd200 + 32'(i), 32'd300 + 32'(i));
      step();
      if (vecs[i].op == 4'b1001) exp_cnt++;
      check_eq($sformatf("vec%0d_op", i), {28'd0, Operation}, {28'd0, vecs[i].op});
      check_eq($sformatf("vec%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].op == 4'b1001});
      check_eq($sformatf("vec%0d_srca", i), SrcA, 32'd100 + 32'(i));
      check_eq($sformatf("vec%0d_srcb", i), SrcB,
               vecs[i].src ? 32'd300 + 32'(i) : 32'd200 + 32'(i));
      check_eq($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("vec%0d_count", i), {24'd0, illegal_count}, exp_cnt);
    end
    in_valid = 1'b0;
    step();
    check_eq("drain_valid", {31'd0, out_valid}, 32'd0);

    // Stall for 3 cycles: outputs hold, in_ready low.
    drive(2'b10, 3'b110, 7'h00, 1'b0, 32'h111, 32'h222, 32'h333);
    step();
    out_ready = 1'b0;
    drive(2'b10, 3'b100, 7'h00, 1'b1, 32'h444, 32'h555, 32'h666);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      check_eq($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("stall%0d_srca", c), SrcA, 32'h111);
      check_eq($sformatf("stall%0d_srcb", c), SrcB, 32'h222);
      check_eq($sformatf("stall%0d_op", c), {28'd0, Operation}, 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("nobubble_valid", {31'd0, out_valid}, 32'd1);
    check_eq("nobubble_srca", SrcA, 32'h444);
    check_eq("nobubble_srcb", SrcB, 32'h666);
    check_eq("nobubble_op", {28'd0, Operation}, 32'h4);

    // Flush during a stall with an illegal instruction waiting.
    out_ready = 1'b0;
    drive(2'b10, 3'b011, 7'h00, 1'b0, 32'h777, 32'h888, 32'h999);
    flush = 1'b1;
    step();
    check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_count", {24'd0, illegal_count}, exp_cnt);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check_eq("flush_nothing_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_nothing_srca", SrcA, 32'h444);
    out_ready = 1'b1;

    // 300 illegal instructions back-to-back: count saturates.
    drive(2'b10, 3'b011, 7'h00, 1'b0, 32'd1, 32'd2, 32'd3);
    for (int k = 0; k < 300; k++) begin
      step();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check_eq($sformatf("ill%0d_op", k), {28'd0, Operation}, 32'h9);
      check_eq($sformatf("ill%0d_flag", k), {31'd0, illegal}, 32'd1);
      check_eq($sformatf("ill%0d_count", k), {24'd0, illegal_count}, exp_cnt);
    end
    check_eq("ill_sat_count", {24'd0, illegal_count}, 32'd255);

    // Reset during a stall, with flush and a valid input also present.
    drive(2'b10, 3'b000, 7'h00, 1'b1, 32'hAAA, 32'hBBB, 32'hCCC);
    step();
    out_ready = 1'b0;
    step();
    check_eq("prerst_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1; flush = 1'b1;
    step();
    check_reset_state("midrst");
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand width.
REQ-002 Parameter OPCODE_LENGTH, default 4: width of the Operation code driven to the ALU.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 in_valid  input  1: upstream decode presents a valid instruction.
REQ-006 in_ready  output  1: the stage accepts the input this cycle.
REQ-007 ALUOp  input  2: class. 00 load/store, 01 branch, 10 R/I arithmetic, 11 LUI.
REQ-008 Funct3  input  3 and Funct7  input  7: instruction function fields.
REQ-009 ALUSrc  input  1: 1 selects Imm as SrcB; 0 selects rs2_data.
REQ-010 rs1_data, rs2_data, Imm  input  DATA_WIDTH each: operands.
REQ-011 flush  input  1: discard the held and incoming instruction.
REQ-012 out_valid  output  1 and out_ready  input  1: downstream handshake.
REQ-013 SrcA, SrcB  output  DATA_WIDTH and Operation  output  OPCODE_LENGTH: registered ALU inputs.
REQ-014 illegal  output  1: the held Operation came from an unsupported encoding.
REQ-015 illegal_count  output  8: saturating count of accepted illegal instructions.

Function
REQ-016 Operation encoding SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SRL 0101, LUI 0111, EQ 1000, SLT 1100, SLL 1110, SRA 1111, ILLEGAL 1001.
REQ-017 The ALUOp=00 encoding SHALL map to ADD, and the ALUOp=11 encoding SHALL map to LUI.
REQ-018 ALUOp=01 with Funct3 000 or 001 SHALL map to EQ; any other Funct3 SHALL map to ILLEGAL.
REQ-019 ALUOp=10 SHALL decode Funct3 as follows: 000 gives ADD, or SUB when ALUSrc=0 and Funct7=0100000; 001 gives SLL; 010 gives SLT; 100 gives XOR; 101 gives SRA when Funct7=0100000, otherwise SRL; 110 gives OR; 111 gives AND; 011 gives ILLEGAL.
REQ-020 SrcA SHALL equal rs1_data, and SrcB SHALL equal ALUSrc ? Imm : rs2_data, both captured unmodified.
REQ-021 The block SHALL be a single register stage: an input is accepted when in_valid && in_ready, and it appears at the outputs with out_valid=1 on the following cycle, giving a latency of 1.
REQ-022 in_ready SHALL equal !out_valid || out_ready, computed combinationally.
REQ-023 While out_valid && !out_ready, SrcA, SrcB, Operation and illegal SHALL hold stable.
REQ-024 When out_ready=1 and no input is accepted, out_valid SHALL clear next cycle. A simultaneous drain and accept SHALL load the new instruction without a bubble.
REQ-025 flush=1 SHALL clear out_valid next cycle, suppress acceptance that cycle, and leave illegal_count unchanged; flush SHALL have priority over all other events.
REQ-026 illegal_count SHALL increment on each accepted ILLEGAL instruction and saturate at 255.
REQ-027 Held data outputs SHALL update only on acceptance. Their values while out_valid=0 carry no meaning, except immediately after reset.

Reset
REQ-028 On reset, out_valid, illegal and illegal_count SHALL be 0, SrcA and SrcB SHALL be 0, and Operation SHALL be 0000.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction; reset SHALL take priority over flush and acceptance.

Structure
REQ-030 The Operation encodings and the ALUOp class values SHALL be defined as constants in a shared package, imported here and by the ALU.
REQ-031 The combinational decode SHALL live in one sub-module, alu_op_decode, with inputs ALUOp, Funct3, Funct7 and ALUSrc, and outputs Operation and illegal.

Verification
REQ-032 ALUOp=10, Funct3=000, Funct7=0100000, ALUSrc=0, rs1=10, rs2=3 -> next cycle Operation=0011, SrcA=10, SrcB=3, out_valid=1.
REQ-033 ALUOp=10, Funct3=101, Funct7=0100000, ALUSrc=1, Imm=4 -> Operation=1111, SrcB=4. The same with Funct7=0 -> Operation=0101.
REQ-034 Hold out_ready=0 for 3 cycles after an accept -> in_ready=0 and outputs stable. Raise out_ready with in_valid=1 -> the next instruction appears with no bubble.
REQ-035 ALUOp=10, Funct3=011 accepted 300 times back-to-back -> illegal=1 and Operation=1001 on each, illegal_count=255 at the end.
REQ-036 flush during a stall with in_valid=1 -> out_valid=0 next cycle and nothing accepted. Reset during a stall -> all outputs at their REQ-028 values.
